// File: rtl/bus_arb_pkg.sv
// Shared types for the two-requester bus arbiter.
//   state_e      : transfer sequencer states
//   R_CPU/R_DMA  : requester indices (bit position in req/ack/err vectors)
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  localparam logic R_CPU = 1'b0;
  localparam logic R_DMA = 1'b1;

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester and bus-fabric signals of the arbiter, bundled.
//   req/we/addr/wdata  : per-requester transfer request (index 0 = cpu, 1 = dma)
//   ack/err/rdata      : per-requester completion pulse, timeout flag, read data
//   bus_clk/we/addr/wdata : registered bus strobe and request fields
//   bus_rdata/bus_data_ready : bus read data and transfer-complete
//   busy/owner         : sequencer not idle, current/last granted requester
// slave  = arbiter side, master = requesters + fabric side.
interface bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [1:0]         req;
  logic [1:0]         we;
  logic [1:0][AW-1:0] addr;
  logic [1:0][DW-1:0] wdata;
  logic [1:0]         ack;
  logic [1:0]         err;
  logic [1:0][DW-1:0] rdata;
  logic               bus_clk;
  logic               bus_we;
  logic [AW-1:0]      bus_addr;
  logic [DW-1:0]      bus_wdata;
  logic [DW-1:0]      bus_rdata;
  logic               bus_data_ready;
  logic               busy;
  logic               owner;

  modport slave (
    input  req, we, addr, wdata, bus_rdata, bus_data_ready,
    output ack, err, rdata, bus_clk, bus_we, bus_addr, bus_wdata, busy, owner
  );

  modport master (
    output req, we, addr, wdata, bus_rdata, bus_data_ready,
    input  ack, err, rdata, bus_clk, bus_we, bus_addr, bus_wdata, busy, owner
  );
endinterface

// File: rtl/bus_arbiter_rr_arb2.sv
// Combinational 2-way pick: fixed priority to R0 (prio=1) or round-robin
// away from the last granted requester (prio=0). A lone request always wins.
//   req[1:0] : requests       last : last granted index    prio : fixed-priority mode
//   gnt      : winning index  gnt_vld : any request present
module rr_arb2
  import bus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio,
  output logic       gnt,
  output logic       gnt_vld
);

  always_comb begin
    gnt_vld = |req;
    gnt     = R_CPU;
    case (req)
      2'b01:   gnt = R_CPU;
      2'b10:   gnt = R_DMA;
      2'b11:   gnt = prio ? R_CPU : ~last;
      default: gnt = R_CPU;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one external bus between the cpu (R0) and the dma agent (R1).
// Each transfer: arbitrate in IDLE, hold strobe in XFER until ready or
// timeout, then one RECOVER cycle so strobes are always separated.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bif     : requester + bus signals (slave modport)
// Parameters: AW/DW widths, TIMEOUT (0 = wait forever), R0_PRIORITY (1 = fixed).
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255,
  parameter int R0_PRIORITY = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  bus_arbiter_if.slave  bif
);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_XFER    = ST_XFER;
  localparam logic [1:0] S_RECOVER = ST_RECOVER;

  // Counter sized to hold TIMEOUT; kept at least one bit for TIMEOUT=0.
  localparam int          CW       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TO_LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0] CNT_LAST = TO_LAST[CW-1:0];
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam bit          TO_EN    = (TIMEOUT != 0);
  localparam bit          PRIO     = (R0_PRIORITY != 0);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               owner_q, owner_d;
  logic               bus_clk_q, bus_clk_d;
  logic               bus_we_q, bus_we_d;
  logic [AW-1:0]      bus_addr_q, bus_addr_d;
  logic [DW-1:0]      bus_wdata_q, bus_wdata_d;
  logic [1:0]         ack_q, ack_d;
  logic [1:0]         err_q, err_d;
  logic [1:0][DW-1:0] rdata_q, rdata_d;

  logic gnt, gnt_vld;

  rr_arb2 u_arb (
    .req     (bif.req),
    .last    (last_q),
    .prio    (PRIO),
    .gnt     (gnt),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    owner_d     = owner_q;
    bus_clk_d   = bus_clk_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    ack_d       = '0;        // ack/err are single-cycle pulses
    err_d       = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          state_d     = S_XFER;
          bus_clk_d   = 1'b1;
          bus_we_d    = bif.we[gnt];
          bus_addr_d  = bif.addr[gnt];
          bus_wdata_d = bif.wdata[gnt];
          cnt_d       = '0;
          last_d      = gnt;
          owner_d     = gnt;
        end
      end
      S_XFER: begin
        // Ready is checked first so it beats a timeout on the same edge.
        if (bif.bus_data_ready) begin
          state_d        = S_RECOVER;
          bus_clk_d      = 1'b0;
          ack_d[owner_q] = 1'b1;
          if (!bus_we_q) rdata_d[owner_q] = bif.bus_rdata;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d        = S_RECOVER;
          bus_clk_d      = 1'b0;
          ack_d[owner_q] = 1'b1;
          err_d[owner_q] = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RECOVER: state_d = S_IDLE;
      default: begin
        state_d   = S_IDLE;
        bus_clk_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_q      <= R_DMA;    // so R0 wins the first contested grant
      owner_q     <= 1'b0;
      bus_clk_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      bus_clk_q   <= bus_clk_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bif.bus_clk   = bus_clk_q;
  assign bif.bus_we    = bus_we_q;
  assign bif.bus_addr  = bus_addr_q;
  assign bif.bus_wdata = bus_wdata_q;
  assign bif.ack       = ack_q;
  assign bif.err       = err_q;
  assign bif.rdata     = rdata_q;
  assign bif.busy      = (state_q != S_IDLE);
  assign bif.owner     = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a per-cycle vector table for the main
// read/write/alternation flow, then hand sequences for timeout, reset
// mid-transfer and fixed-priority starvation (second instance).
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_nb = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if #(.AW(32), .DW(32)) ifa ();
  bus_arbiter_if #(.AW(32), .DW(32)) ifb ();

  bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(4), .R0_PRIORITY(0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bif(ifa.slave));
  bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(0), .R0_PRIORITY(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_nb), .bif(ifb.slave));

  int n_run = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic        rdy;
    logic [31:0] bd;
    logic        clk_e;
    logic [1:0]  ack_e;
    logic        own_e;
    logic        busy_e;
    logic [31:0] rd0_e;
    logic [31:0] rd1_e;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] req, logic [1:0] we, logic rdy, logic [31:0] bd,
                              logic c, logic [1:0] a, logic o, logic b,
                              logic [31:0] r0, logic [31:0] r1);
    vec_t v;
    v.req = req; v.we = we; v.rdy = rdy; v.bd = bd;
    v.clk_e = c; v.ack_e = a; v.own_e = o; v.busy_e = b; v.rd0_e = r0; v.rd1_e = r1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drv_a(input logic [1:0] req, input logic [1:0] we, input logic rdy,
                       input logic [31:0] bd);
    ifa.req = req; ifa.we = we; ifa.bus_data_ready = rdy; ifa.bus_rdata = bd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1;
    ifa.addr[0] = 32'h0000_1234; ifa.addr[1] = 32'h0000_8000;
    ifa.wdata[0] = 32'h0BAD_F00D; ifa.wdata[1] = 32'hDEAD_BEEF;
    ifb.addr = ifa.addr; ifb.wdata = ifa.wdata;
    drv_a(2'b00, 2'b00, 1'b0, 32'h0);
    ifb.req = 2'b00; ifb.we = 2'b00; ifb.bus_data_ready = 1'b0; ifb.bus_rdata = 32'h0;

    // req, we, rdy, bus_rdata | bus_clk, ack, owner, busy, rdata0, rdata1
    tbl.push_back(mk(2'b01, 2'b00, 0, 32'h00, 1, 2'b00, 0, 1, 32'h00, 32'h00)); // R0 read grant
    tbl.push_back(mk(2'b01, 2'b00, 0, 32'h00, 1, 2'b00, 0, 1, 32'h00, 32'h00));
    tbl.push_back(mk(2'b01, 2'b00, 0, 32'h00, 1, 2'b00, 0, 1, 32'h00, 32'h00));
    tbl.push_back(mk(2'b01, 2'b00, 1, 32'hA5, 0, 2'b01, 0, 1, 32'hA5, 32'h00)); // ready
    tbl.push_back(mk(2'b00, 2'b00, 0, 32'h00, 0, 2'b00, 0, 0, 32'hA5, 32'h00)); // recover
    tbl.push_back(mk(2'b10, 2'b10, 0, 32'h00, 1, 2'b00, 1, 1, 32'hA5, 32'h00)); // R1 write
    tbl.push_back(mk(2'b10, 2'b10, 0, 32'h00, 1, 2'b00, 1, 1, 32'hA5, 32'h00));
    tbl.push_back(mk(2'b10, 2'b10, 1, 32'h5555, 0, 2'b10, 1, 1, 32'hA5, 32'h00));
    tbl.push_back(mk(2'b00, 2'b10, 0, 32'h00, 0, 2'b00, 1, 0, 32'hA5, 32'h00));
    tbl.push_back(mk(2'b11, 2'b10, 1, 32'h11, 1, 2'b00, 0, 1, 32'hA5, 32'h00)); // ready ignored in idle
    tbl.push_back(mk(2'b11, 2'b10, 1, 32'h22, 0, 2'b01, 0, 1, 32'h22, 32'h00));
    tbl.push_back(mk(2'b11, 2'b10, 1, 32'h99, 0, 2'b00, 0, 0, 32'h22, 32'h00));
    tbl.push_back(mk(2'b11, 2'b10, 1, 32'h33, 1, 2'b00, 1, 1, 32'h22, 32'h00));
    tbl.push_back(mk(2'b11, 2'b10, 1, 32'h44, 0, 2'b10, 1, 1, 32'h22, 32'h00));
    tbl.push_back(mk(2'b11, 2'b10, 1, 32'h88, 0, 2'b00, 1, 0, 32'h22, 32'h00));
    tbl.push_back(mk(2'b11, 2'b10, 1, 32'h55, 1, 2'b00, 0, 1, 32'h22, 32'h00));
    tbl.push_back(mk(2'b11, 2'b10, 1, 32'h66, 0, 2'b01, 0, 1, 32'h66, 32'h00));
    tbl.push_back(mk(2'b11, 2'b10, 1, 32'h77, 0, 2'b00, 0, 0, 32'h66, 32'h00));
    tbl.push_back(mk(2'b10, 2'b00, 0, 32'h00, 1, 2'b00, 1, 1, 32'h66, 32'h00)); // R1 read
    tbl.push_back(mk(2'b10, 2'b00, 1, 32'h77, 0, 2'b10, 1, 1, 32'h66, 32'h77));
    tbl.push_back(mk(2'b00, 2'b00, 0, 32'h00, 0, 2'b00, 1, 0, 32'h66, 32'h77));

    // Reset state
    #12;
    chk("rst bus_clk", 32'(ifa.bus_clk), 32'h0);
    chk("rst ack", 32'(ifa.ack), 32'h0);
    chk("rst err", 32'(ifa.err), 32'h0);
    chk("rst busy", 32'(ifa.busy), 32'h0);
    chk("rst owner", 32'(ifa.owner), 32'h0);
    chk("rst bus_addr", ifa.bus_addr, 32'h0);
    chk("rst rdata0", ifa.rdata[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rst_nb = 1'b1;

    // Vector table
    for (int i = 0; i < tbl.size(); i++) begin
      drv_a(tbl[i].req, tbl[i].we, tbl[i].rdy, tbl[i].bd);
      tick();
      chk($sformatf("v%0d bus_clk", i), 32'(ifa.bus_clk), 32'(tbl[i].clk_e));
      chk($sformatf("v%0d ack", i), 32'(ifa.ack), 32'(tbl[i].ack_e));
      chk($sformatf("v%0d err", i), 32'(ifa.err), 32'h0);
      chk($sformatf("v%0d owner", i), 32'(ifa.owner), 32'(tbl[i].own_e));
      chk($sformatf("v%0d busy", i), 32'(ifa.busy), 32'(tbl[i].busy_e));
      chk($sformatf("v%0d rdata0", i), ifa.rdata[0], tbl[i].rd0_e);
      chk($sformatf("v%0d rdata1", i), ifa.rdata[1], tbl[i].rd1_e);
      if (tbl[i].clk_e) begin
        chk($sformatf("v%0d bus_we", i), 32'(ifa.bus_we), 32'(tbl[i].we[tbl[i].own_e]));
        chk($sformatf("v%0d bus_addr", i), ifa.bus_addr,
            tbl[i].own_e ? 32'h0000_8000 : 32'h0000_1234);
        chk($sformatf("v%0d bus_wdata", i), ifa.bus_wdata,
            tbl[i].own_e ? 32'hDEAD_BEEF : 32'h0BAD_F00D);
      end
    end

    // Timeout: TIMEOUT=4, ready never comes
    drv_a(2'b01, 2'b00, 1'b0, 32'h0);
    tick();
    chk("to grant clk", 32'(ifa.bus_clk), 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("to xfer%0d clk", k), 32'(ifa.bus_clk), 32'h1);
    end
    tick();
    chk("to drop clk", 32'(ifa.bus_clk), 32'h0);
    chk("to ack", 32'(ifa.ack), 32'h1);
    chk("to err", 32'(ifa.err), 32'h1);
    chk("to rdata0 kept", ifa.rdata[0], 32'h66);
    drv_a(2'b00, 2'b00, 1'b0, 32'h0);
    tick();
    chk("to recover ack", 32'(ifa.ack), 32'h0);
    chk("to recover err", 32'(ifa.err), 32'h0);
    chk("to recover busy", 32'(ifa.busy), 32'h0);

    // Ready on the timeout edge: ready wins
    drv_a(2'b01, 2'b00, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) tick();
    drv_a(2'b01, 2'b00, 1'b1, 32'hC3);
    tick();
    chk("torace ack", 32'(ifa.ack), 32'h1);
    chk("torace err", 32'(ifa.err), 32'h0);
    chk("torace rdata0", ifa.rdata[0], 32'hC3);
    chk("torace clk", 32'(ifa.bus_clk), 32'h0);
    drv_a(2'b00, 2'b00, 1'b0, 32'h0);
    tick();

    // Reset in the middle of an R1 transfer
    drv_a(2'b10, 2'b10, 1'b0, 32'h0);
    tick();
    chk("rstx grant owner", 32'(ifa.owner), 32'h1);
    chk("rstx grant clk", 32'(ifa.bus_clk), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstx clk", 32'(ifa.bus_clk), 32'h0);
    chk("rstx ack", 32'(ifa.ack), 32'h0);
    chk("rstx busy", 32'(ifa.busy), 32'h0);
    chk("rstx owner", 32'(ifa.owner), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drv_a(2'b11, 2'b10, 1'b0, 32'h0);
    tick();
    chk("rstx next owner", 32'(ifa.owner), 32'h0);
    chk("rstx next clk", 32'(ifa.bus_clk), 32'h1);
    drv_a(2'b11, 2'b10, 1'b1, 32'hE7);
    tick();
    chk("rstx next ack", 32'(ifa.ack), 32'h1);
    chk("rstx next rdata0", ifa.rdata[0], 32'hE7);
    drv_a(2'b00, 2'b00, 1'b0, 32'h0);
    tick();
    chk("rstx idle", 32'(ifa.busy), 32'h0);

    // Fixed priority: R0 held continuously starves R1
    ifb.req = 2'b11; ifb.we = 2'b00; ifb.bus_data_ready = 1'b1; ifb.bus_rdata = 32'h1B;
    a0 = 0; a1 = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("prio c%0d double ack", k), 32'(&ifb.ack), 32'h0);
      if (ifb.ack[0]) a0++;
      if (ifb.ack[1]) a1++;
    end
    chk("prio r0 acks", 32'(a0), 32'd4);
    chk("prio r1 acks", 32'(a1), 32'd0);

    // TIMEOUT=0: waits indefinitely for ready
    ifb.req = 2'b10; ifb.bus_data_ready = 1'b0;
    tick();
    chk("prio r1 owner", 32'(ifb.owner), 32'h1);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("noto c%0d clk", k), 32'(ifb.bus_clk), 32'h1);
      chk($sformatf("noto c%0d ack", k), 32'(ifb.ack), 32'h0);
    end
    ifb.bus_data_ready = 1'b1; ifb.bus_rdata = 32'h0B0B;
    tick();
    chk("noto ack", 32'(ifb.ack), 32'h2);
    chk("noto err", 32'(ifb.err), 32'h0);
    chk("noto rdata1", ifb.rdata[1], 32'h0B0B);
    ifb.req = 2'b00; ifb.bus_data_ready = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
